// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: forwarding
// selects, load-use and branch handling, and a data-memory wait FSM with timeout trap.
module hazard_ctrl #(
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int MEM_TIMEOUT            = 16,
    parameter int COUNT_WIDTH            = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs1D_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs2D_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs1E_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs2E_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] rdE_i,
    input  logic                              ResultSrcE_i,
    input  logic                              PCSrcE_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] rdM_i,
    input  logic                              regWriteM_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] rdW_i,
    input  logic                              regWriteW_i,
    input  logic                              memReqM_i,
    input  logic                              memAckM_i,
    output logic                              stallF_o,
    output logic                              stallD_o,
    output logic                              stallE_o,
    output logic                              stallM_o,
    output logic                              flushD_o,
    output logic                              flushE_o,
    output logic [1:0]                        forwardAE_o,
    output logic [1:0]                        forwardBE_o,
    output logic                              memErr_o,
    output logic [COUNT_WIDTH-1:0]            stallCycles_o,
    output logic [1:0]                        fsm_state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lw_stall;
    logic              mem_stall;

    // M-stage result is newer than W-stage, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [REGISTER_ADDRESS_WIDTH-1:0] rs);
        if (regWriteM_i && (rdM_i != '0) && (rdM_i == rs))
            return 2'b10;
        else if (regWriteW_i && (rdW_i != '0) && (rdW_i == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        forwardAE_o = fwd_sel(rs1E_i);
        forwardBE_o = fwd_sel(rs2E_i);

        lw_stall = ResultSrcE_i && (rdE_i != '0) &&
                   ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

        mem_stall = 1'b0;
        case (state)
            RUN:      mem_stall = memReqM_i && !memAckM_i;
            MEM_WAIT: mem_stall = !memAckM_i;
            ERROR:    mem_stall = 1'b1;
            default:  mem_stall = 1'b0;
        endcase

        stallF_o = lw_stall || mem_stall;
        stallD_o = lw_stall || mem_stall;
        stallE_o = mem_stall;
        stallM_o = mem_stall;
        // A frozen pipeline must not drop a redirect; it is reapplied on release.
        flushD_o = PCSrcE_i && !mem_stall;
        flushE_o = (lw_stall || PCSrcE_i) && !mem_stall;

        fsm_state_o = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            wait_cnt      <= '0;
            memErr_o      <= 1'b0;
            stallCycles_o <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (memReqM_i && !memAckM_i) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (memAckM_i) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= ERROR;
                        memErr_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERROR: begin
                    memErr_o <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase

            if (stallF_o && (stallCycles_o != '1))
                stallCycles_o <= stallCycles_o + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: driver pushes hand-computed expectations,
// a negedge monitor pops and compares; a second instance checks 4-bit saturation.
module tb_hazard_ctrl;

    localparam int RAW = 5;
    localparam int VW  = 31;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [RAW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic           ld_e, pcsrc, rw_m, rw_w, req, ack;

    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_err;
    logic [1:0]  fwd_a, fwd_b, fsm_state;
    logic [15:0] cnt16;

    logic        s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_flush_d, s_flush_e, s_mem_err;
    logic [1:0]  s_fwd_a, s_fwd_b, s_fsm_state;
    logic [3:0]  cnt4;

    logic [VW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [15:0]   exp_cnt16;
    logic [3:0]    exp_cnt4;

    always #5 clk = ~clk;

    hazard_ctrl #(.REGISTER_ADDRESS_WIDTH(RAW), .MEM_TIMEOUT(16), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E), .rdE_i(rdE),
        .ResultSrcE_i(ld_e), .PCSrcE_i(pcsrc), .rdM_i(rdM), .regWriteM_i(rw_m),
        .rdW_i(rdW), .regWriteW_i(rw_w), .memReqM_i(req), .memAckM_i(ack),
        .stallF_o(stall_f), .stallD_o(stall_d), .stallE_o(stall_e), .stallM_o(stall_m),
        .flushD_o(flush_d), .flushE_o(flush_e), .forwardAE_o(fwd_a), .forwardBE_o(fwd_b),
        .memErr_o(mem_err), .stallCycles_o(cnt16), .fsm_state_o(fsm_state)
    );

    hazard_ctrl #(.REGISTER_ADDRESS_WIDTH(RAW), .MEM_TIMEOUT(16), .COUNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E), .rdE_i(rdE),
        .ResultSrcE_i(ld_e), .PCSrcE_i(pcsrc), .rdM_i(rdM), .regWriteM_i(rw_m),
        .rdW_i(rdW), .regWriteW_i(rw_w), .memReqM_i(req), .memAckM_i(ack),
        .stallF_o(s_stall_f), .stallD_o(s_stall_d), .stallE_o(s_stall_e), .stallM_o(s_stall_m),
        .flushD_o(s_flush_d), .flushE_o(s_flush_e), .forwardAE_o(s_fwd_a), .forwardBE_o(s_fwd_b),
        .memErr_o(s_mem_err), .stallCycles_o(cnt4), .fsm_state_o(s_fsm_state)
    );

    // Monitor: compare whenever an expectation is pending, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [VW-1:0] act, exp_v;
            string         nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act   = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
                     fwd_a, fwd_b, mem_err, cnt16, cnt4};
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (sF sD sE sM fD fE fA fB err cnt16 cnt4)",
                         nm, act, exp_v);
            end
        end
    end

    task automatic idle();
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
        ld_e = 1'b0; pcsrc = 1'b0; rw_m = 1'b0; rw_w = 1'b0; req = 1'b0; ack = 1'b0;
    endtask

    // Inputs are already applied; push the expectation and advance one cycle.
    task automatic expect_out(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                              input logic sf, input logic se, input logic fd, input logic fe,
                              input logic err);
        if (!rst_n) begin
            exp_cnt16 = '0;
            exp_cnt4  = '0;
        end
        exp_q.push_back({sf, sf, se, se, fd, fe, fa, fb, err, exp_cnt16, exp_cnt4});
        name_q.push_back(nm);
        if (rst_n && sf) begin
            if (exp_cnt16 != 16'hffff) exp_cnt16 = exp_cnt16 + 16'd1;
            if (exp_cnt4 != 4'hf)      exp_cnt4  = exp_cnt4 + 4'd1;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_cnt16 = '0;
        exp_cnt4  = '0;
        rst_n = 1'b0;
        idle();
        expect_out("reset_state", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Forwarding
        idle(); rs1E = 5; rdM = 5; rw_m = 1;
        expect_out("fwdA_from_M", 2'b10, 2'b00, 0, 0, 0, 0, 0);
        idle(); rs1E = 5; rdW = 5; rw_w = 1;
        expect_out("fwdA_from_W", 2'b01, 2'b00, 0, 0, 0, 0, 0);
        idle(); rs2E = 7; rdW = 7; rw_w = 1; rs1E = 3; rdM = 3; rw_m = 1;
        expect_out("fwdB_W_fwdA_M", 2'b10, 2'b01, 0, 0, 0, 0, 0);
        idle(); rs1E = 9; rs2E = 9; rdM = 9; rw_m = 1; rdW = 9; rw_w = 1;
        expect_out("fwd_M_beats_W", 2'b10, 2'b10, 0, 0, 0, 0, 0);
        idle(); rs1E = 0; rs2E = 0; rdM = 0; rw_m = 1; rdW = 0; rw_w = 1;
        expect_out("fwd_x0_none", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        idle(); rs1E = 5; rdM = 5; rw_m = 0; rs2E = 6; rdW = 6; rw_w = 0;
        expect_out("fwd_no_regwrite", 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Load-use
        idle(); ld_e = 1; rdE = 6; rs1D = 6;
        expect_out("lw_use_rs1", 2'b00, 2'b00, 1, 0, 0, 1, 0);
        idle(); ld_e = 1; rdE = 6; rs2D = 6; rs1D = 2;
        expect_out("lw_use_rs2", 2'b00, 2'b00, 1, 0, 0, 1, 0);
        idle(); ld_e = 1; rdE = 0; rs1D = 0;
        expect_out("lw_x0_no_stall", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        idle(); ld_e = 0; rdE = 6; rs1D = 6;
        expect_out("non_load_no_stall", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        idle(); pcsrc = 1;
        expect_out("branch_flush_run", 2'b00, 2'b00, 0, 0, 1, 1, 0);

        // Single-cycle access and 3-cycle wait
        idle(); req = 1; ack = 1;
        expect_out("mem_single_cycle", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle(); req = 1;
            expect_out($sformatf("mem_wait_%0d", i), 2'b00, 2'b00, 1, 1, 0, 0, 0);
        end
        idle(); req = 1; ack = 1;
        expect_out("mem_ack_release", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        idle();
        expect_out("back_in_run", 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Branch held during MEM_WAIT, applied on ack; load-use masked too
        idle(); req = 1; pcsrc = 1;
        expect_out("br_hold_run", 2'b00, 2'b00, 1, 1, 0, 0, 0);
        idle(); req = 1; pcsrc = 1;
        expect_out("br_hold_wait", 2'b00, 2'b00, 1, 1, 0, 0, 0);
        idle(); req = 1; pcsrc = 1; ld_e = 1; rdE = 4; rs2D = 4;
        expect_out("br_lw_hold_wait", 2'b00, 2'b00, 1, 1, 0, 0, 0);
        idle(); req = 1; ack = 1; pcsrc = 1;
        expect_out("br_flush_on_ack", 2'b00, 2'b00, 0, 0, 1, 1, 0);

        // Timeout from a fresh reset; also drives the 4-bit counter into saturation
        idle(); rst_n = 1'b0;
        expect_out("reset_before_timeout", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            idle(); req = 1;
            expect_out($sformatf("timeout_wait_%0d", i), 2'b00, 2'b00, 1, 1, 0, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            idle(); req = 1; ack = 1; pcsrc = 1;
            expect_out($sformatf("error_held_%0d", i), 2'b00, 2'b00, 1, 1, 0, 0, 1);
        end

        // Reset asserted between edges must clear the error immediately
        idle(); rst_n = 1'b0;
        expect_out("async_reset_clears_err", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        idle(); rs1E = 1; rdM = 1; rw_m = 1;
        expect_out("run_after_reset", 2'b10, 2'b00, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
